// File: rtl/execute_writeback_history.sv
// Two-deep writeback history (WB, PREV_WB) feeding execute-stage forwarding,
// plus the architectural stack pointer copy that every entry carries.
`ifndef SYSREG_SPR
`define SYSREG_SPR 5'd8
`endif

module execute_writeback_history #(
   parameter logic [31:0] SPR_INIT = 32'h0000_0000
) (
   input  logic        iCLOCK,
   input  logic        iRESET_SYNC,
   input  logic        iFLUSH,
   input  logic        iHOLD,
   input  logic        iCOMMIT_GR_VALID,
   input  logic [31:0] iCOMMIT_GR_DATA,
   input  logic [4:0]  iCOMMIT_GR_DEST,
   input  logic        iCOMMIT_GR_DEST_SYSREG,
   input  logic        iCOMMIT_SPR_VALID,
   input  logic [31:0] iCOMMIT_SPR_DATA,
   output logic        oWB_GR_VALID,
   output logic [31:0] oWB_GR_DATA,
   output logic [4:0]  oWB_GR_DEST,
   output logic        oWB_GR_DEST_SYSREG,
   output logic        oWB_SPR_VALID,
   output logic [31:0] oWB_SPR_DATA,
   output logic        oPREV_WB_GR_VALID,
   output logic [31:0] oPREV_WB_GR_DATA,
   output logic [4:0]  oPREV_WB_GR_DEST,
   output logic        oPREV_WB_GR_DEST_SYSREG,
   output logic        oPREV_WB_SPR_VALID,
   output logic [31:0] oPREV_WB_SPR_DATA,
   output logic [31:0] oARCH_SPR
);

   typedef struct packed {
      logic        grValid;
      logic [31:0] grData;
      logic [4:0]  grDest;
      logic        grDestSysreg;
      logic        sprValid;
      logic [31:0] sprData;
   } entry_t;

   entry_t      wb_q, wb_d;
   entry_t      prev_q, prev_d;
   entry_t      newEntry;
   logic [31:0] archSpr_q, archSpr_d;
   logic        commit;
   logic        sprGr;

   assign commit = iCOMMIT_GR_VALID | iCOMMIT_SPR_VALID;
   assign sprGr  = iCOMMIT_GR_VALID & iCOMMIT_GR_DEST_SYSREG &
                   (iCOMMIT_GR_DEST == `SYSREG_SPR);

   // Explicit SPR writeback outranks a sysreg write of the same register.
   always_comb begin
      newEntry.grValid      = iCOMMIT_GR_VALID;
      newEntry.grData       = iCOMMIT_GR_DATA;
      newEntry.grDest       = iCOMMIT_GR_DEST;
      newEntry.grDestSysreg = iCOMMIT_GR_DEST_SYSREG;
      newEntry.sprValid     = iCOMMIT_SPR_VALID | sprGr;
      if (iCOMMIT_SPR_VALID)
         newEntry.sprData = iCOMMIT_SPR_DATA;
      else if (sprGr)
         newEntry.sprData = iCOMMIT_GR_DATA;
      else
         newEntry.sprData = archSpr_q;
   end

   always_comb begin
      wb_d      = wb_q;
      prev_d    = prev_q;
      archSpr_d = archSpr_q;
      if (newEntry.sprValid)
         archSpr_d = newEntry.sprData;
      if (iFLUSH) begin
         prev_d.grValid  = 1'b0;
         prev_d.sprValid = 1'b0;
         if (commit) begin
            wb_d = newEntry;
         end else begin
            wb_d.grValid  = 1'b0;
            wb_d.sprValid = 1'b0;
            wb_d.sprData  = archSpr_q;
         end
      end else if (commit) begin
         prev_d = wb_q;
         wb_d   = newEntry;
      end else if (!iHOLD) begin
         // Bubble keeps the live SPR so forwarding fallback stays correct.
         prev_d        = wb_q;
         wb_d.grValid  = 1'b0;
         wb_d.sprValid = 1'b0;
         wb_d.sprData  = archSpr_q;
      end
   end

   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         wb_q      <= '{default: '0, sprData: SPR_INIT};
         prev_q    <= '{default: '0, sprData: SPR_INIT};
         archSpr_q <= SPR_INIT;
      end else begin
         wb_q      <= wb_d;
         prev_q    <= prev_d;
         archSpr_q <= archSpr_d;
      end
   end

   assign oWB_GR_VALID            = wb_q.grValid;
   assign oWB_GR_DATA             = wb_q.grData;
   assign oWB_GR_DEST             = wb_q.grDest;
   assign oWB_GR_DEST_SYSREG      = wb_q.grDestSysreg;
   assign oWB_SPR_VALID           = wb_q.sprValid;
   assign oWB_SPR_DATA            = wb_q.sprData;
   assign oPREV_WB_GR_VALID       = prev_q.grValid;
   assign oPREV_WB_GR_DATA        = prev_q.grData;
   assign oPREV_WB_GR_DEST        = prev_q.grDest;
   assign oPREV_WB_GR_DEST_SYSREG = prev_q.grDestSysreg;
   assign oPREV_WB_SPR_VALID      = prev_q.sprValid;
   assign oPREV_WB_SPR_DATA       = prev_q.sprData;
   assign oARCH_SPR               = archSpr_q;

endmodule

// File: doc/execute_writeback_history.md
Name: execute_writeback_history

Overview:
- Registers the commit/writeback bus of the execute pipeline into a two-deep history: WB (most recent) and PREV_WB (one older).
- Directly feeds the execute-stage operand forwarding block through its iWB_* and iPREV_WB_* inputs.
- Maintains the architectural stack pointer copy (SPR). Every history entry therefore carries a meaningful SPR value, even when that entry did not write SPR.

Parameters:
- SPR_INIT, 32'h0000_0000, reset value of the architectural SPR copy.

Ports:
- iCLOCK  in  1  core clock
- iRESET_SYNC  in  1  synchronous reset, active-high
- iFLUSH  in  1  pipeline flush (branch/exception)
- iHOLD  in  1  execute stage stalled; history must not age
- iCOMMIT_GR_VALID  in  1  GR/sysreg writeback this cycle
- iCOMMIT_GR_DATA  in  32  writeback data
- iCOMMIT_GR_DEST  in  5  destination pointer
- iCOMMIT_GR_DEST_SYSREG  in  1  destination is a system register
- iCOMMIT_SPR_VALID  in  1  implicit SPR writeback this cycle (push/pop)
- iCOMMIT_SPR_DATA  in  32  new SPR value
- oWB_GR_VALID  out  1  / oWB_GR_DATA out 32 / oWB_GR_DEST out 5 / oWB_GR_DEST_SYSREG out 1
- oWB_SPR_VALID  out  1  / oWB_SPR_DATA out 32
- oPREV_WB_GR_VALID  out  1  / oPREV_WB_GR_DATA out 32 / oPREV_WB_GR_DEST out 5 / oPREV_WB_GR_DEST_SYSREG out 1
- oPREV_WB_SPR_VALID  out  1  / oPREV_WB_SPR_DATA out 32
- oARCH_SPR  out  32  architectural SPR value

Behaviour:
- All outputs are registered on the rising edge of iCLOCK.
- Reset (iRESET_SYNC=1, highest priority):
  - All VALID outputs = 0.
  - All DATA and DEST outputs = 0; DEST_SYSREG outputs = 0.
  - oARCH_SPR = SPR_INIT.
  - oWB_SPR_DATA = oPREV_WB_SPR_DATA = SPR_INIT.
- commit = iCOMMIT_GR_VALID | iCOMMIT_SPR_VALID.
- New entry:
  - GR fields are copied from the commit bus. GR_DATA/DEST/SYSREG are latched even when GR_VALID=0.
  - SPR_VALID = iCOMMIT_SPR_VALID | spr_gr, where spr_gr = iCOMMIT_GR_VALID & iCOMMIT_GR_DEST_SYSREG & (iCOMMIT_GR_DEST == `SYSREG_SPR).
  - SPR_DATA = iCOMMIT_SPR_DATA if iCOMMIT_SPR_VALID; else iCOMMIT_GR_DATA if spr_gr; else the current oARCH_SPR.
- oARCH_SPR update:
  - Takes the new entry's SPR_DATA whenever its SPR_VALID=1.
  - Updates independently of iHOLD and iFLUSH.
  - If iCOMMIT_SPR_VALID and spr_gr are both set, iCOMMIT_SPR_DATA wins.
- History update, evaluated in priority order:
  1. iFLUSH=1:
     - PREV valids := 0.
     - If commit, WB := new entry; else WB valids := 0.
     - A commit is never discarded by a flush.
  2. commit=1: PREV := WB and WB := new entry, regardless of iHOLD.
  3. iHOLD=1, no commit: WB and PREV hold. Entries must stay visible to a stalled consumer.
  4. Otherwise, bubble shift:
     - PREV := WB.
     - WB valids := 0, WB_SPR_DATA := oARCH_SPR, WB GR fields hold.
- A bubble's SPR_DATA always equals the SPR value in effect. The forwarding block's SPR fallback is therefore always correct.
- Latency: a commit appears on oWB_* one cycle later and on oPREV_WB_* two cycles later, unless frozen by iHOLD or cleared by iFLUSH.
- Reset asserted mid-stream discards all history on the same edge. The first commit after reset is captured normally.

Test Plan:
- Reset: hold iRESET_SYNC with SPR_INIT=32'h0000_F000 -> all valids 0, oARCH_SPR and both SPR_DATA outputs = 32'h0000_F000.
- GR commit r3=32'hDEAD_BEEF, then idle (iHOLD=0):
  - Cycle+1: oWB_GR_VALID=1, DEST=3.
  - Cycle+2: oPREV_WB_GR_VALID=1, DATA=32'hDEAD_BEEF, oWB_GR_VALID=0.
  - Cycle+3: both valids 0.
- Hold: commit r5=32'h1, then iHOLD=1 for 3 cycles with no commit -> oWB_GR_VALID stays 1, DEST=5 for all 3 cycles. A commit r6 during the hold moves r5 to PREV and r6 to WB.
- SPR paths:
  - iCOMMIT_SPR_VALID with data 32'h0000_EFFC -> oARCH_SPR=32'h0000_EFFC, oWB_SPR_VALID=1.
  - Sysreg write to `SYSREG_SPR with 32'h0000_8000 -> oARCH_SPR=32'h0000_8000, oWB_SPR_VALID=1.
  - Both in the same cycle (SPR_DATA 32'h10, GR_DATA 32'h20) -> 32'h10.
- Flush:
  - iFLUSH with WB and PREV valid and no commit -> all valids 0 next cycle, oARCH_SPR unchanged.
  - iFLUSH coincident with commit r7 -> oWB_GR_VALID=1, DEST=7, PREV valids 0.
- Bubble SPR carry: SPR commit 32'h100, then 2 idle cycles -> oWB_SPR_VALID=0, oWB_SPR_DATA=32'h100, oPREV_WB_SPR_DATA=32'h100.
